branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Sequences the branch quick-compare unit in the ID stage of the MIPS pipeline.
- Decodes branch/jump class, drives the compare inputs, and stalls ID until the forwarded operands are valid.
- Computes the target, then issues a held redirect to fetch through a valid/ready handshake.
- Produces the link write for AL/JAL forms and keeps taken/resolved statistics counters.

Parameters:
- CNT_W, 16, width of the statistics counters (saturating).
- WAIT_MAX, 15, max operand-wait cycles before wait_timeout pulses (diagnostic only; stall continues).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_instr  in  32  ID instruction word
- id_pc  in  32  PC of the ID instruction
- opa, opb  in  32  forwarded rs/rt values
- opa_rdy, opb_rdy  in  1  forwarded value is final (no pending load/ALU result)
- cmp_instr  out  32  to compare Instr_input
- cmp_jump  out  1  to compare Jump
- cmp_taken  in  1  from compare taken
- id_stall  out  1  hold IF/ID
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target
- redir_ready  in  1  fetch accepts redirect
- link_we  out  1  one-cycle link write strobe
- link_rd  out  5  link register (31, or rd for JALR)
- link_data  out  32  id_pc+8
- br_count, tk_count  out  CNT_W  resolved / taken control-transfer counts
- wait_timeout  out  1  one-cycle pulse

Behaviour:
- Classes, decoded from id_instr:
  - BR: opcode 000001 (rt 00000/00001/10000/10001), 000100, 000101, 000110, 000111.
  - J: 000010, 000011.
  - JR: opcode 000000 with funct 001000/001001.
  - NONE: everything else.
- cmp_instr = id_instr when the class is not NONE, else 0.
- cmp_jump = 1 for J/JR classes.
- Operand needs:
  - BEQ/BNE need opa_rdy & opb_rdy.
  - Other BR forms and JR need opa_rdy only.
  - J needs nothing.
- Targets:
  - BR: id_pc+4 + (sext(instr[15:0])<<2), 32-bit wrap.
  - J: {pc4[31:28], instr[25:0], 2'b00}.
  - JR: opa.
- States: IDLE, WAIT_OPS, REDIR.
- IDLE:
  - id_valid & class NONE: no action, id_stall=0.
  - Control transfer with operands not ready: id_stall=1 -> WAIT_OPS; wait counter cleared.
  - Control transfer with operands ready: resolve this cycle.
- Resolve:
  - br_count++.
  - If cmp_taken: tk_count++, register redir_pc, redir_valid=1 next cycle -> REDIR.
  - AL forms (BLTZAL/BGEZAL, JAL, JALR) pulse link_we in the resolve cycle regardless of taken.
  - Not taken: stay IDLE, zero latency, no stall.
- WAIT_OPS:
  - id_stall=1, wait counter increments.
  - wait_timeout pulses once when the counter reaches WAIT_MAX; the counter saturates.
  - When the needed readies are present, resolve as above in that cycle (stall drops that cycle).
- REDIR:
  - redir_valid=1 and id_stall=1.
  - redir_pc is stable until the handshake.
  - On redir_valid & redir_ready: next cycle redir_valid=0, -> IDLE.
  - Delay-slot fetch is fetch's responsibility; this block never flushes.
- Counters saturate at all-ones.
- Reset (asynchronous, any state, including mid-REDIR or mid-WAIT_OPS):
  - state=IDLE.
  - redir_valid, redir_pc, link_we, link_rd, link_data, wait_timeout, wait counter, br_count, tk_count = 0.
  - Pending redirect is discarded.
- id_valid=0 in IDLE: no resolve, no counts.
- Inputs are ignored while in REDIR.

Decomposition:
- Shared package mips_pkg holds opcode/funct/rt constants (OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL, FN_JR, FN_JALR), the branch class enum, and the ctrl state enum.
- One sub-module branch_target_gen (combinational target + link_rd select); the existing compare block is instantiated externally.

Test Plan:
- BEQ at id_pc=0x00400010, imm=0x0004, opa=opb=5, both ready -> same-cycle resolve, next cycle redir_valid=1, redir_pc=0x00400024, tk_count=1.
- BNE with opa=opb=7 -> not taken, no stall, redir_valid stays 0, br_count=1, tk_count=0.
- BGEZAL with opa=0xFFFFFFFF, ready -> not taken; link_we=1, link_rd=31, link_data=id_pc+8.
- JR with opa_rdy low for 3 cycles, opa=0x00400100 -> id_stall high 3 cycles, then redirect to 0x00400100; redir_ready held low 2 cycles -> redir_pc stable, redir_valid held until accept.
- opa_rdy low for 20 cycles, WAIT_MAX=15 -> single wait_timeout pulse at the 15th wait cycle, stall persists until ready.
- Assert rst while in REDIR with redir_ready=0 -> redir_valid=0 immediately (asynchronous), state IDLE, counters 0; first branch after reset resolves normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Opcode/funct constants, branch class and controller state types shared by the branch path.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;
  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_BR   = 2'd1,
    CLS_J    = 2'd2,
    CLS_JR   = 2'd3
  } br_class_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_OPS = 2'd1,
    S_REDIR    = 2'd2
  } ctrl_state_e;

  function automatic br_class_e decode_class(input logic [31:0] instr);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    br_class_e  cls;
    op  = instr[31:26];
    rt  = instr[20:16];
    fn  = instr[5:0];
    cls = CLS_NONE;
    case (op)
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL)
          cls = CLS_BR;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BR;
      OP_J, OP_JAL:                     cls = CLS_J;
      OP_SPECIAL: begin
        if (fn == FN_JR || fn == FN_JALR)
          cls = CLS_JR;
      end
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// ID-stage branch controller bundle: instruction/operands in, compare, redirect and link out.
interface branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc;
  logic [31:0]      opa;
  logic [31:0]      opb;
  logic             opa_rdy;
  logic             opb_rdy;
  logic [31:0]      cmp_instr;
  logic             cmp_jump;
  logic             cmp_taken;
  logic             id_stall;
  logic             redir_valid;
  logic [31:0]      redir_pc;
  logic             redir_ready;
  logic             link_we;
  logic [4:0]       link_rd;
  logic [31:0]      link_data;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] tk_count;
  logic             wait_timeout;

  modport master (
    output id_valid, id_instr, id_pc, opa, opb, opa_rdy, opb_rdy, cmp_taken, redir_ready,
    input  cmp_instr, cmp_jump, id_stall, redir_valid, redir_pc,
           link_we, link_rd, link_data, br_count, tk_count, wait_timeout
  );

  modport slave (
    input  id_valid, id_instr, id_pc, opa, opb, opa_rdy, opb_rdy, cmp_taken, redir_ready,
    output cmp_instr, cmp_jump, id_stall, redir_valid, redir_pc,
           link_we, link_rd, link_data, br_count, tk_count, wait_timeout
  );
endinterface

// File: rtl/branch_target_gen.sv
// Combinational control-transfer target, link-form detect and link register/data select.
module branch_target_gen
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_opa,
  input  br_class_e   i_cls,
  output logic [31:0] o_target,
  output logic        o_link,
  output logic [4:0]  o_link_rd,
  output logic [31:0] o_link_data
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [5:0]  w_fn;

  assign w_pc4    = i_pc + 32'd4;
  assign w_br_off = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_op     = i_instr[31:26];
  assign w_rt     = i_instr[20:16];
  assign w_fn     = i_instr[5:0];

  always_comb begin
    o_target  = 32'd0;
    o_link    = 1'b0;
    o_link_rd = REG_RA;
    case (i_cls)
      CLS_BR: begin
        o_target = w_pc4 + w_br_off;
        // Only the REGIMM AL forms (BLTZAL/BGEZAL) have rt[4] set among decoded branches.
        o_link   = (w_op == OP_REGIMM) && w_rt[4];
      end
      CLS_J: begin
        o_target = {w_pc4[31:28], i_instr[25:0], 2'b00};
        o_link   = (w_op == OP_JAL);
      end
      CLS_JR: begin
        o_target  = i_opa;
        o_link    = (w_fn == FN_JALR);
        o_link_rd = i_instr[15:11];
      end
      default: begin
        o_target = 32'd0;
      end
    endcase
  end

  assign o_link_data = i_pc + 32'd8;

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: operand-wait stall, same-cycle resolve, held redirect handshake, link strobe, stats.
module branch_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic      clk,
  input  logic      rst,
  branch_ctrl_if.slave bus
);

  localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_PRE  = WAIT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  ctrl_state_e r_state;
  ctrl_state_e w_next;

  logic              r_redir_valid;
  logic [31:0]       r_redir_pc;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_wait_timeout;
  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_tk_count;

  br_class_e   w_cls;
  logic [5:0]  w_op;
  logic        w_ctrl;
  logic        w_ops_rdy;
  logic        w_resolve;
  logic        w_taken;
  logic        w_stall;
  logic [31:0] w_target;
  logic        w_link;
  logic [4:0]  w_link_rd;
  logic [31:0] w_link_data;
  logic        w_link_we;

  assign w_cls   = decode_class(bus.id_instr);
  assign w_op    = bus.id_instr[31:26];
  // Nothing may resolve while reset is held, so the link strobe stays low too.
  assign w_ctrl  = !rst && bus.id_valid && (w_cls != CLS_NONE);
  assign w_taken = w_resolve && bus.cmp_taken;

  always_comb begin
    w_ops_rdy = 1'b0;
    case (w_cls)
      CLS_BR: begin
        if (w_op == OP_BEQ || w_op == OP_BNE)
          w_ops_rdy = bus.opa_rdy && bus.opb_rdy;
        else
          w_ops_rdy = bus.opa_rdy;
      end
      CLS_JR:  w_ops_rdy = bus.opa_rdy;
      CLS_J:   w_ops_rdy = 1'b1;
      default: w_ops_rdy = 1'b0;
    endcase
  end

  branch_target_gen u_target (
    .i_instr     (bus.id_instr),
    .i_pc        (bus.id_pc),
    .i_opa       (bus.opa),
    .i_cls       (w_cls),
    .o_target    (w_target),
    .o_link      (w_link),
    .o_link_rd   (w_link_rd),
    .o_link_data (w_link_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_resolve = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ctrl) begin
          if (w_ops_rdy) begin
            w_resolve = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = S_WAIT_OPS;
          end
        end
      end
      S_WAIT_OPS: begin
        if (!w_ctrl) begin
          w_next = S_IDLE;
        end else if (w_ops_rdy) begin
          w_resolve = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_REDIR: begin
        w_stall = 1'b1;
        if (r_redir_valid && bus.redir_ready)
          w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_resolve)
      w_next = bus.cmp_taken ? S_REDIR : S_IDLE;
  end

  // Redirect target is captured at resolve and held untouched until fetch accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'd0;
    end else if (w_taken) begin
      r_redir_valid <= 1'b1;
      r_redir_pc    <= w_target;
    end else if (r_state == S_REDIR && bus.redir_ready) begin
      r_redir_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt     <= '0;
      r_wait_timeout <= 1'b0;
    end else begin
      r_wait_timeout <= 1'b0;
      if (r_state != S_WAIT_OPS) begin
        r_wait_cnt <= '0;
      end else if (w_stall) begin
        if (r_wait_cnt != WAIT_LAST)
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        r_wait_timeout <= (r_wait_cnt == WAIT_PRE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count <= '0;
      r_tk_count <= '0;
    end else begin
      if (w_resolve && r_br_count != CNT_SAT)
        r_br_count <= r_br_count + CNT_W'(1);
      if (w_taken && r_tk_count != CNT_SAT)
        r_tk_count <= r_tk_count + CNT_W'(1);
    end
  end

  assign w_link_we = w_resolve && w_link;

  assign bus.cmp_instr    = (w_cls != CLS_NONE) ? bus.id_instr : 32'd0;
  assign bus.cmp_jump     = (w_cls == CLS_J) || (w_cls == CLS_JR);
  assign bus.id_stall     = w_stall;
  assign bus.redir_valid  = r_redir_valid;
  assign bus.redir_pc     = r_redir_pc;
  assign bus.link_we      = w_link_we;
  assign bus.link_rd      = w_link_we ? w_link_rd : 5'd0;
  assign bus.link_data    = w_link_we ? w_link_data : 32'd0;
  assign bus.br_count     = r_br_count;
  assign bus.tk_count     = r_tk_count;
  assign bus.wait_timeout = r_wait_timeout;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed plus randomized bench for branch_ctrl against a transaction-level branch model.
module tb_branch_ctrl;

  localparam int CNT_W    = 16;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_br     = 0;
  int m_tk     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
    logic [5:0] o; logic [4:0] s; logic [4:0] t;
    o = 6'(op); s = 5'(rs); t = 5'(rt);
    return {o, s, t, imm};
  endfunction

  function automatic logic [31:0] rtype_jr(input int rs, input int rd, input int fn);
    logic [4:0] s; logic [4:0] d; logic [5:0] f;
    s = 5'(rs); d = 5'(rd); f = 6'(fn);
    return {6'd0, s, 5'd0, d, 5'd0, f};
  endfunction

  // Model: 0 = not a control transfer, 1 = branch, 2 = jump, 3 = register jump.
  function automatic int kind_of(input logic [31:0] ins);
    int op, rt, fn;
    op = int'(ins[31:26]); rt = int'(ins[20:16]); fn = int'(ins[5:0]);
    if (op == 1) return (rt == 0 || rt == 1 || rt == 16 || rt == 17) ? 1 : 0;
    if (op >= 4 && op <= 7) return 1;
    if (op == 2 || op == 3) return 2;
    if (op == 0 && (fn == 8 || fn == 9)) return 3;
    return 0;
  endfunction

  function automatic logic is_taken(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    int op;
    op = int'(ins[31:26]);
    case (op)
      4: return a == b;
      5: return a != b;
      6: return $signed(a) <= 0;
      7: return $signed(a) > 0;
      1: return ins[16] ? ($signed(a) >= 0) : ($signed(a) < 0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a);
    int k;
    logic [31:0] pc4;
    k = kind_of(ins);
    pc4 = pc + 4;
    if (k == 1) return pc4 + 32'($signed(ins[15:0]) * 4);
    if (k == 2) return {pc4[31:28], ins[25:0], 2'b00};
    return a;
  endfunction

  task automatic bump_counts(input logic taken);
    if (m_br < (1 << CNT_W) - 1) m_br++;
    if (taken && m_tk < (1 << CNT_W) - 1) m_tk++;
  endtask

  task automatic chk_counts();
    chk("br_count", 32'(bus.br_count), 32'(m_br));
    chk("tk_count", 32'(bus.tk_count), 32'(m_tk));
  endtask

  // One control transfer: d cycles of missing operands, then r cycles of fetch refusing the redirect.
  task automatic run_xfer(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                          input logic [31:0] b, input int d, input int r);
    int k, op, de, pulses;
    logic need_a, need_b, tk, lnk;
    logic [31:0] tgt;
    logic [4:0] lrd;
    k      = kind_of(ins);
    op     = int'(ins[31:26]);
    need_a = (k == 1) || (k == 3);
    need_b = (k == 1) && (op == 4 || op == 5);
    tk     = is_taken(ins, a, b);
    tgt    = target_of(ins, pc, a);
    lnk    = (op == 1 && ins[20]) || op == 3 || (k == 3 && ins[5:0] == 6'd9);
    lrd    = (k == 3) ? ins[15:11] : 5'd31;
    de     = (need_a || need_b) ? d : 0;
    pulses = 0;
    for (int c = 0; c <= de; c++) begin
      @(negedge clk);
      bus.id_valid    = 1'b1;
      bus.id_instr    = ins;
      bus.id_pc       = pc;
      bus.opa         = a;
      bus.opb         = b;
      bus.opa_rdy     = need_a ? (c >= de) : 1'($urandom);
      bus.opb_rdy     = need_b ? (c >= de) : 1'($urandom);
      bus.cmp_taken   = tk;
      bus.redir_ready = 1'($urandom);
      #1;
      chk("id_stall", 32'(bus.id_stall), 32'(c < de));
      chk("redir_valid_idle", 32'(bus.redir_valid), 32'd0);
      chk("link_we", 32'(bus.link_we), 32'(c == de && lnk));
      if (c == de && lnk) begin
        chk("link_rd", 32'(bus.link_rd), 32'(lrd));
        chk("link_data", bus.link_data, pc + 32'd8);
      end
      chk("wait_timeout", 32'(bus.wait_timeout), 32'(c == WAIT_MAX + 1));
      if (bus.wait_timeout === 1'b1) pulses++;
      chk("cmp_instr", bus.cmp_instr, ins);
      chk("cmp_jump", 32'(bus.cmp_jump), 32'(k >= 2));
      chk_counts();
    end
    if (de > WAIT_MAX) chk("timeout_pulses", 32'(pulses), 32'd1);
    bump_counts(tk);
    if (tk) begin
      for (int m = 0; m <= r; m++) begin
        @(negedge clk);
        bus.id_valid    = 1'($urandom);
        bus.id_instr    = itype(4, 1, 1, 16'($urandom));
        bus.opa_rdy     = 1'b1;
        bus.opb_rdy     = 1'b1;
        bus.cmp_taken   = 1'($urandom);
        bus.redir_ready = (m == r);
        #1;
        chk("redir_valid", 32'(bus.redir_valid), 32'd1);
        chk("redir_pc", bus.redir_pc, tgt);
        chk("stall_redir", 32'(bus.id_stall), 32'd1);
        chk("link_we_redir", 32'(bus.link_we), 32'd0);
        chk_counts();
      end
    end
  endtask

  task automatic idle_step(input logic vld, input logic [31:0] ins);
    @(negedge clk);
    bus.id_valid  = vld;
    bus.id_instr  = ins;
    bus.id_pc     = $urandom & 32'hFFFF_FFFC;
    bus.opa_rdy   = 1'b1;
    bus.opb_rdy   = 1'b1;
    bus.cmp_taken = 1'b1;
    #1;
    chk("idle_stall", 32'(bus.id_stall), 32'd0);
    chk("idle_link_we", 32'(bus.link_we), 32'd0);
    chk("idle_redir_valid", 32'(bus.redir_valid), 32'd0);
    chk("idle_cmp_instr", bus.cmp_instr, (kind_of(ins) != 0) ? ins : 32'd0);
    chk_counts();
  endtask

  initial begin
    logic [31:0] ins, a, b, pc;
    int sel, rt;
    rst             = 1'b1;
    bus.id_valid    = 1'b0;
    bus.id_instr    = 32'd0;
    bus.id_pc       = 32'd0;
    bus.opa         = 32'd0;
    bus.opb         = 32'd0;
    bus.opa_rdy     = 1'b0;
    bus.opb_rdy     = 1'b0;
    bus.cmp_taken   = 1'b0;
    bus.redir_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_redir_valid", 32'(bus.redir_valid), 32'd0);
    chk("rst_redir_pc", bus.redir_pc, 32'd0);
    chk("rst_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_timeout", 32'(bus.wait_timeout), 32'd0);
    chk_counts();
    rst = 1'b0;

    run_xfer(itype(4, 1, 2, 16'h0004), 32'h0040_0010, 32'd5, 32'd5, 0, 0);
    chk("beq_target_const", bus.redir_pc, 32'h0040_0024);
    run_xfer(itype(5, 1, 2, 16'h0010), 32'h0040_0100, 32'd7, 32'd7, 0, 0);
    run_xfer(itype(1, 3, 17, 16'h0008), 32'h0040_0200, 32'hFFFF_FFFF, 32'd0, 0, 0);
    run_xfer(rtype_jr(4, 0, 8), 32'h0040_0300, 32'h0040_0100, 32'd0, 3, 2);
    run_xfer(itype(7, 5, 0, 16'hFFF0), 32'h0040_0400, 32'd9, 32'd0, 20, 1);
    idle_step(1'b0, itype(4, 1, 1, 16'h0001));
    idle_step(1'b1, itype(8, 1, 1, 16'h0001));
    idle_step(1'b1, itype(1, 1, 2, 16'h0001));

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 8);
      a   = $urandom;
      b   = ($urandom_range(0, 1) == 1) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'd0;
      pc  = $urandom & 32'hFFFF_FFFC;
      rt  = 0;
      case (sel)
        0, 1, 2, 3: ins = itype(4 + sel, 1, 2, 16'($urandom));
        4: begin
          case ($urandom_range(0, 3))
            0: rt = 0; 1: rt = 1; 2: rt = 16; default: rt = 17;
          endcase
          ins = itype(1, 1, rt, 16'($urandom));
        end
        5: ins = {6'd2, 26'($urandom)};
        6: ins = {6'd3, 26'($urandom)};
        7: ins = rtype_jr(2, $urandom_range(1, 30), $urandom_range(8, 9));
        default: ins = itype(8, 1, 2, 16'($urandom));
      endcase
      if (kind_of(ins) == 0)
        idle_step(1'b1, ins);
      else
        run_xfer(ins, pc, a, b, $urandom_range(0, 4), $urandom_range(0, 2));
    end

    // Reset while a redirect is waiting for fetch.
    @(negedge clk);
    bus.id_valid    = 1'b1;
    bus.id_instr    = itype(4, 1, 2, 16'h0020);
    bus.id_pc       = 32'h0040_0800;
    bus.opa         = 32'd1;
    bus.opb         = 32'd1;
    bus.opa_rdy     = 1'b1;
    bus.opb_rdy     = 1'b1;
    bus.cmp_taken   = 1'b1;
    bus.redir_ready = 1'b0;
    @(negedge clk);
    bus.id_valid = 1'b0;
    #1;
    chk("pre_rst_redir_valid", 32'(bus.redir_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    m_br = 0;
    m_tk = 0;
    chk("arst_redir_valid", 32'(bus.redir_valid), 32'd0);
    chk("arst_redir_pc", bus.redir_pc, 32'd0);
    chk("arst_stall", 32'(bus.id_stall), 32'd0);
    chk_counts();
    @(negedge clk);
    rst = 1'b0;
    idle_step(1'b0, 32'd0);
    run_xfer(itype(4, 1, 2, 16'h0004), 32'h0040_0010, 32'd3, 32'd3, 1, 0);
    idle_step(1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
